asi_ram_arb: RTL and testbench

//  N-port arbiter/bridge that lets several ASI-style RAM masters (addr/cen/wen/wdata/rdata) share one

---
 rtl/asi_ram_arb_pkg.sv | 22 ++
 rtl/asi_ram_arb_rr.sv | 56 +++++
 rtl/asi_ram_arb.sv | 126 ++++++++++++
 tb/tb_asi_ram_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asi_ram_arb_pkg.sv
// Shared constants and helpers for the ASI RAM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package asi_ram_arb_pkg;

  localparam int NPORT_DEF  = 2;
  localparam int DW_DEF     = 128;
  localparam int AW_DEF     = 10;
  localparam int RD_LAT_DEF = 1;

  // Active-low byte enables all deasserted means the transfer is a read.
  // Sized for the widest supported data bus; users take the low BW bits.
  localparam logic [127:0] WEN_READ = '1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/asi_ram_arb_rr.sv
// Round-robin grant over NPORT requesters with a registered last-winner pointer.
// Latency: grant is combinational from req and the pointer; pointer updates on accept.
// Backpressure: ungranted requesters simply see gnt low and must hold.
//
// Ports: clk, rst (sync, active-high), req[NPORT], gnt[NPORT] (one-hot),
//        gnt_idx[PW] (binary index of the granted port, valid when |gnt).
module asi_ram_arb_rr
  import asi_ram_arb_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int PW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  output logic [NPORT-1:0] gnt,
  output logic [PW-1:0]    gnt_idx
);

  if (NPORT == 1) begin : g_single
    logic unused_clk;
    assign unused_clk = clk;
    assign gnt        = req & {NPORT{~rst}};
    assign gnt_idx    = '0;
  end else begin : g_multi
    logic [PW-1:0] ptr;
    logic          found;
    int            q;

    // Search starts one past the last winner and wraps, so the previous
    // winner has the lowest priority this cycle.
    always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      q       = 0;
      for (int i = 1; i <= NPORT; i++) begin
        q = int'(ptr) + i;
        if (q >= NPORT) q = q - NPORT;
        if (!found && req[q]) begin
          found   = 1'b1;
          gnt[q]  = 1'b1;
          gnt_idx = PW'(q);
        end
      end
      if (rst) gnt = '0;
    end

    // Reset to the last port so port 0 wins the first contention.
    always_ff @(posedge clk) begin
      if (rst) ptr <= PW'(NPORT - 1);
      else if (|gnt) ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/asi_ram_arb.sv
// N-port ASI master to single-port synchronous RAM bridge with round-robin arbitration.
// Latency: accept at T drives the RAM at T+1; read data + m_rvalid at T+2+RD_LAT, in accept order.
// Backpressure: one accept per cycle; losing ports see m_gnt low and hold their request.
//
// Ports: m_req/m_addr/m_wen/m_wdata per port (packed, port p at slice p), m_gnt one-hot,
//        m_rvalid one-hot read strobe, m_rdata broadcast; ram_cen/ram_addr/ram_wen/ram_wdata
//        registered RAM drive, ram_rdata from RAM.
// Optional: define ASI_RAM_ARB_STATS_EN to add stat_clr and per-port 16-bit stall counters.
module asi_ram_arb
  import asi_ram_arb_pkg::*;
#(
  parameter int NPORT  = NPORT_DEF,
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  localparam int BW    = DW / 8,
  localparam int LB    = clog2(BW),
  localparam int RAW   = AW - LB,
  localparam int PW    = (NPORT > 1) ? clog2(NPORT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    m_req,
  input  logic [NPORT*AW-1:0] m_addr,
  input  logic [NPORT*BW-1:0] m_wen,
  input  logic [NPORT*DW-1:0] m_wdata,
  output logic [NPORT-1:0]    m_gnt,
  output logic [NPORT-1:0]    m_rvalid,
  output logic [DW-1:0]       m_rdata,
  output logic                ram_cen,
  output logic [RAW-1:0]      ram_addr,
  output logic [BW-1:0]       ram_wen,
  output logic [DW-1:0]       ram_wdata,
  input  logic [DW-1:0]       ram_rdata
`ifdef ASI_RAM_ARB_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [NPORT*16-1:0] stat_stall
`endif
);

  logic [PW-1:0]  gnt_idx;
  logic           acc;
  logic           is_rd;
  logic [AW-1:0]  sel_addr;
  logic [BW-1:0]  sel_wen;
  logic [DW-1:0]  sel_wdata;
  logic           unused_addr_lsb;

  asi_ram_arb_rr #(.NPORT(NPORT), .PW(PW)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (m_req),
    .gnt     (m_gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is one-hot (or zero), so an AND-OR mux selects the winner's fields.
  always_comb begin
    sel_addr  = '0;
    sel_wen   = '0;
    sel_wdata = '0;
    for (int p = 0; p < NPORT; p++) begin
      sel_addr  = sel_addr  | (m_addr[p*AW +: AW]  & {AW{m_gnt[p]}});
      sel_wen   = sel_wen   | (m_wen[p*BW +: BW]   & {BW{m_gnt[p]}});
      sel_wdata = sel_wdata | (m_wdata[p*DW +: DW] & {DW{m_gnt[p]}});
    end
  end

  assign acc             = |m_gnt;
  assign is_rd           = (sel_wen == WEN_READ[BW-1:0]);
  // Byte-offset bits never reach the word-addressed RAM.
  assign unused_addr_lsb = ^sel_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_cen   <= 1'b1;
      ram_wen   <= '1;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (acc) begin
      ram_cen   <= 1'b0;
      ram_wen   <= sel_wen;
      ram_addr  <= sel_addr[AW-1:LB];
      ram_wdata <= sel_wdata;
    end else begin
      ram_cen   <= 1'b1;
      ram_wen   <= '1;
    end
  end

  // Read-return tag pipe: stage k holds the read issued to the RAM k cycles
  // ago; stage RD_LAT lines up with ram_rdata for that read.
  logic [RD_LAT:0] rp_vld;
  logic [PW-1:0]   rp_idx [RD_LAT+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rp_vld   <= '0;
      for (int k = 0; k <= RD_LAT; k++) rp_idx[k] <= '0;
      m_rvalid <= '0;
      m_rdata  <= '0;
    end else begin
      rp_vld    <= {rp_vld[RD_LAT-1:0], acc & is_rd};
      rp_idx[0] <= gnt_idx;
      for (int k = 1; k <= RD_LAT; k++) rp_idx[k] <= rp_idx[k-1];
      for (int p = 0; p < NPORT; p++)
        m_rvalid[p] <= rp_vld[RD_LAT] && (rp_idx[RD_LAT] == PW'(p));
      if (rp_vld[RD_LAT]) m_rdata <= ram_rdata;
    end
  end

`ifdef ASI_RAM_ARB_STATS_EN
  for (genvar p = 0; p < NPORT; p++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (rst || stat_clr) cnt <= '0;
      else if (m_req[p] && !m_gnt[p] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign stat_stall[p*16 +: 16] = cnt;
  end
`else
  // No stall counters in this build; the datapath is unaffected either way.
`endif

endmodule

// File: tb/tb_asi_ram_arb.sv
// Bench for asi_ram_arb: table-driven directed vectors on a 2-port/RD_LAT=1 instance,
// hand-written ordering sequence and randomized scoreboard run on a 4-port/RD_LAT=3 instance.
// Behavioural RAMs with preloaded contents sit behind both instances.
module tb_asi_ram_arb;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [127:0] init2(input int w);
    logic [31:0] x;
    x = 32'(w) * 32'h9E3779B1;
    return {x, ~x, x ^ 32'h5555AAAA, x + 32'd7};
  endfunction

  function automatic logic [31:0] init4(input int w);
    return (32'(w) * 32'h01000193) ^ 32'hC0FFEE00;
  endfunction

  // ---------------- 2-port instance, 128-bit, RD_LAT=1 ----------------
  logic [1:0]   m_req2, m_gnt2, m_rvalid2;
  logic [19:0]  m_addr2;
  logic [31:0]  m_wen2;
  logic [255:0] m_wdata2;
  logic [127:0] m_rdata2, ram_wdata2, ram_rdata2;
  logic         ram_cen2;
  logic [5:0]   ram_addr2;
  logic [15:0]  ram_wen2;
  logic [127:0] mem2 [64];

  asi_ram_arb #(.NPORT(2), .DW(128), .AW(10), .RD_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .m_req(m_req2), .m_addr(m_addr2), .m_wen(m_wen2),
    .m_wdata(m_wdata2), .m_gnt(m_gnt2), .m_rvalid(m_rvalid2), .m_rdata(m_rdata2),
    .ram_cen(ram_cen2), .ram_addr(ram_addr2), .ram_wen(ram_wen2),
    .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 64; w++) mem2[w] <= init2(w);
    end else if (!ram_cen2) begin
      if (&ram_wen2) ram_rdata2 <= mem2[ram_addr2];
      else for (int b = 0; b < 16; b++)
        if (!ram_wen2[b]) mem2[ram_addr2][b*8 +: 8] <= ram_wdata2[b*8 +: 8];
    end
  end

  // ---------------- 4-port instance, 32-bit, RD_LAT=3 ----------------
  logic [3:0]   m_req4, m_gnt4, m_rvalid4;
  logic [39:0]  m_addr4;
  logic [15:0]  m_wen4;
  logic [127:0] m_wdata4;
  logic [31:0]  m_rdata4, ram_wdata4, ram_rdata4;
  logic         ram_cen4;
  logic [7:0]   ram_addr4;
  logic [3:0]   ram_wen4;
  logic [31:0]  mem4 [256];
  logic [31:0]  r4a, r4b;

  asi_ram_arb #(.NPORT(4), .DW(32), .AW(10), .RD_LAT(3)) dut4 (
    .clk(clk), .rst(rst), .m_req(m_req4), .m_addr(m_addr4), .m_wen(m_wen4),
    .m_wdata(m_wdata4), .m_gnt(m_gnt4), .m_rvalid(m_rvalid4), .m_rdata(m_rdata4),
    .ram_cen(ram_cen4), .ram_addr(ram_addr4), .ram_wen(ram_wen4),
    .ram_wdata(ram_wdata4), .ram_rdata(ram_rdata4)
  );

  // Three register stages between RAM select and data out; idle slots carry junk.
  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 256; w++) mem4[w] <= init4(w);
      r4a <= 32'hBAD0BAD0;
    end else if (!ram_cen4 && &ram_wen4) begin
      r4a <= mem4[ram_addr4];
    end else begin
      r4a <= 32'hBAD0BAD0;
      if (!ram_cen4)
        for (int b = 0; b < 4; b++)
          if (!ram_wen4[b]) mem4[ram_addr4][b*8 +: 8] <= ram_wdata4[b*8 +: 8];
    end
    r4b        <= r4a;
    ram_rdata4 <= r4b;
  end

  // ---------------- 4-port reference model ----------------
  typedef struct { int due; int port; logic [31:0] data; } ret_t;
  ret_t        rq[$];
  logic [31:0] sh4 [256];
  int          rr_last;
  int          cyc;
  logic [3:0]  req4;
  logic [9:0]  a4 [4];
  logic [3:0]  w4 [4];
  logic [31:0] d4 [4];
  logic [3:0]  last_rv4;

  task automatic model_reset4();
    rr_last = 3;
    rq.delete();
    for (int w = 0; w < 256; w++) sh4[w] = init4(w);
    cyc  = 0;
    req4 = '0;
  endtask

  // One cycle: drive pending requests, check grant against the round-robin rule,
  // book the transfer in the shadow memory / return queue, then check returns.
  task automatic step4();
    logic [3:0] exp_g;
    int         gi;
    int         qp;
    logic [7:0] wd;
    for (int p = 0; p < 4; p++) begin
      m_addr4[p*10 +: 10] = a4[p];
      m_wen4[p*4 +: 4]    = w4[p];
      m_wdata4[p*32 +: 32] = d4[p];
    end
    m_req4 = req4;
    #1;
    exp_g = '0;
    gi    = -1;
    for (int i = 1; i <= 4; i++) begin
      qp = (rr_last + i) % 4;
      if (gi < 0 && req4[qp]) gi = qp;
    end
    if (gi >= 0) exp_g[gi] = 1'b1;
    chk($sformatf("gnt4 cyc%0d", cyc), m_gnt4, exp_g);
    if (gi >= 0) begin
      rr_last = gi;
      wd = a4[gi][9:2];
      if (w4[gi] == 4'hF) rq.push_back('{cyc + 5, gi, sh4[wd]});
      else for (int b = 0; b < 4; b++)
        if (!w4[gi][b]) sh4[wd][b*8 +: 8] = d4[gi][b*8 +: 8];
    end
    @(posedge clk);
    #1;
    cyc++;
    if (gi >= 0) req4[gi] = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk($sformatf("rvalid4 cyc%0d", cyc), m_rvalid4, 4'b0001 << rq[0].port);
      chk($sformatf("rdata4 cyc%0d", cyc), m_rdata4, rq[0].data);
      void'(rq.pop_front());
    end else begin
      chk($sformatf("rvalid4 idle cyc%0d", cyc), m_rvalid4, 4'b0000);
    end
    last_rv4 = m_rvalid4;
  endtask

  // ---------------- directed table for the 2-port instance ----------------
  typedef struct {
    logic rst; logic [1:0] req; logic [9:0] a0; logic [9:0] a1; logic [15:0] w1; logic [127:0] d1;
    logic [1:0] gnt; logic cen; logic [5:0] raddr; logic [15:0] rwen; logic [1:0] rv;
    logic chk_rd; logic [127:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] rq_, input logic [9:0] a0,
                              input logic [9:0] a1, input logic [15:0] w1, input logic [127:0] d1,
                              input logic [1:0] g, input logic cen, input logic [5:0] ra,
                              input logic [15:0] rw, input logic [1:0] rv, input logic cr,
                              input logic [127:0] rd);
    vec_t v;
    v = '{r, rq_, a0, a1, w1, d1, g, cen, ra, rw, rv, cr, rd};
    return v;
  endfunction

  vec_t tbl [22];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] F128, Z, A5, tmp, rd13;
    logic [15:0]  F;
    logic [3:0]   rv_exp [3:7];
    logic [3:0]   rvh [0:10];

    F = 16'hFFFF; Z = '0; A5 = {16{8'hA5}}; F128 = '1;
    tmp  = init2(1);
    rd13 = {64'hA5A5A5A5A5A5A5A5, tmp[63:0]};

    tbl[0]  = mk(1, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 0, F, 2'b00, 1, Z);
    tbl[1]  = mk(0, 2'b01, 10'h040, 10'h000, F, Z, 2'b01, 0, 4, F, 2'b00, 0, Z);
    tbl[2]  = mk(0, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 4, F, 2'b00, 0, Z);
    tbl[3]  = mk(0, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 4, F, 2'b01, 1, init2(4));
    tbl[4]  = mk(0, 2'b11, 10'h000, 10'h010, F, Z, 2'b10, 0, 1, F, 2'b00, 0, Z);
    tbl[5]  = mk(0, 2'b11, 10'h000, 10'h010, F, Z, 2'b01, 0, 0, F, 2'b00, 0, Z);
    tbl[6]  = mk(0, 2'b11, 10'h000, 10'h010, F, Z, 2'b10, 0, 1, F, 2'b10, 1, init2(1));
    tbl[7]  = mk(0, 2'b11, 10'h000, 10'h010, F, Z, 2'b01, 0, 0, F, 2'b01, 1, init2(0));
    tbl[8]  = mk(0, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 0, F, 2'b10, 1, init2(1));
    tbl[9]  = mk(0, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 0, F, 2'b01, 1, init2(0));
    tbl[10] = mk(0, 2'b10, 10'h000, 10'h010, 16'h00FF, A5, 2'b10, 0, 1, 16'h00FF, 2'b00, 0, Z);
    tbl[11] = mk(0, 2'b10, 10'h000, 10'h01F, F, Z, 2'b10, 0, 1, F, 2'b00, 0, Z);
    tbl[12] = mk(0, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 1, F, 2'b00, 0, Z);
    tbl[13] = mk(0, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 1, F, 2'b10, 1, rd13);
    tbl[14] = mk(0, 2'b01, 10'h020, 10'h000, F, Z, 2'b01, 0, 2, F, 2'b00, 0, Z);
    tbl[15] = mk(1, 2'b01, 10'h020, 10'h000, F, Z, 2'b00, 1, 0, F, 2'b00, 1, Z);
    tbl[16] = mk(0, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 0, F, 2'b00, 0, Z);
    tbl[17] = mk(0, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 0, F, 2'b00, 0, Z);
    tbl[18] = mk(0, 2'b11, 10'h030, 10'h000, F, Z, 2'b01, 0, 3, F, 2'b00, 0, Z);
    tbl[19] = mk(0, 2'b10, 10'h030, 10'h000, F, Z, 2'b10, 0, 0, F, 2'b00, 0, Z);
    tbl[20] = mk(0, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 0, F, 2'b01, 1, init2(3));
    tbl[21] = mk(0, 2'b00, 10'h000, 10'h000, F, Z, 2'b00, 1, 0, F, 2'b10, 1, init2(0));

    rst = 1'b1;
    m_req2 = '0; m_addr2 = '0; m_wen2 = '1; m_wdata2 = '0;
    m_req4 = '0; m_addr4 = '0; m_wen4 = '1; m_wdata4 = '0;
    for (int p = 0; p < 4; p++) begin a4[p] = '0; w4[p] = 4'hF; d4[p] = '0; end
    req4 = '0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 22; k++) begin
      rst      = tbl[k].rst;
      m_req2   = tbl[k].req;
      m_addr2  = {tbl[k].a1, tbl[k].a0};
      m_wen2   = {tbl[k].w1, 16'hFFFF};
      m_wdata2 = {tbl[k].d1, 128'h0};
      #1;
      chk($sformatf("row%0d gnt", k), m_gnt2, tbl[k].gnt);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d ram_cen", k), ram_cen2, tbl[k].cen);
      chk($sformatf("row%0d ram_addr", k), ram_addr2, tbl[k].raddr);
      chk($sformatf("row%0d ram_wen", k), ram_wen2, tbl[k].rwen);
      chk($sformatf("row%0d m_rvalid", k), m_rvalid2, tbl[k].rv);
      if (tbl[k].chk_rd) chk($sformatf("row%0d m_rdata", k), m_rdata2, tbl[k].rd);
    end
    m_req2 = '0;

    // Reset the 4-port instance and check its idle state.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst4 ram_cen", ram_cen4, 1'b1);
    chk("rst4 ram_wen", ram_wen4, 4'hF);
    chk("rst4 m_rvalid", m_rvalid4, 4'h0);
    chk("rst4 m_rdata", m_rdata4, 32'h0);
    model_reset4();

    // Ordering: reads from ports 3,1,2 on consecutive cycles return in that order.
    rv_exp[3] = 4'b0000; rv_exp[4] = 4'b1000; rv_exp[5] = 4'b0010;
    rv_exp[6] = 4'b0100; rv_exp[7] = 4'b0000;
    a4[3] = 10'h014; w4[3] = 4'hF; req4 = 4'b1000;
    step4(); rvh[0] = last_rv4;
    a4[1] = 10'h02C; w4[1] = 4'hF; req4[1] = 1'b1;
    step4(); rvh[1] = last_rv4;
    a4[2] = 10'h3FC; w4[2] = 4'hF; req4[2] = 1'b1;
    step4(); rvh[2] = last_rv4;
    for (int i = 3; i <= 10; i++) begin step4(); rvh[i] = last_rv4; end
    for (int i = 3; i <= 7; i++) chk($sformatf("order rv step%0d", i), rvh[i], rv_exp[i]);

    // Randomized traffic against the scoreboard; small word range forces RAW collisions.
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < 4; p++) begin
        if (!req4[p]) begin
          if ($urandom % 3 == 0) begin
            a4[p]   = {3'($urandom_range(0, 7)), 5'd0, 2'($urandom)};
            a4[p][9:2] = 8'($urandom_range(0, 7));
            w4[p]   = ($urandom % 2 == 0) ? 4'hF : 4'($urandom);
            d4[p]   = $urandom;
            req4[p] = 1'b1;
          end
        end else if ($urandom % 16 == 0) begin
          req4[p] = 1'b0;
        end
      end
      step4();
    end
    req4 = '0;
    for (int n = 0; n < 12; n++) step4();
    chk("drain queue empty", 128'(rq.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
